div_seq_unit: RTL and testbench
===============================

// Module: div_seq_unit
// PURPOSE
//  Multi-cycle iterative divider for the RV32IM M-extension: DIV, DIVU, REM, REMU.
//  Sits beside the EX-stage ALU and is the sequential counterpart to its divide path.
//  The hazard unit stalls the pipeline while busy is high. Radix-2 restoring
//  algorithm, one quotient bit per clock, with fast paths for divide-by-zero and
//  signed overflow.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk     in   1     clock, rising edge
//  rst_n   in   1     asynchronous reset, active low
//  start   in   1     request strobe; accepted only in IDLE or DONE
//  op      in   2     00=DIV 01=DIVU 10=REM 11=REMU; sampled with start
//  a       in   XLEN  dividend (forwarded RD1E); sampled with start
//  b       in   XLEN  divisor (forwarded RD2E); sampled with start
//  flush   in   1     synchronous abort (branch mispredict/trap)
//  busy    out  1     high while a request is in flight (CALC, FIX)
//  done    out  1     one-cycle pulse; result valid this cycle
//  result  out  XLEN  quotient or remainder; held until next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, busy=0, done=0, result=0, counter=0.
//  States: IDLE, CALC, FIX, DONE.
//  IDLE --start--> CALC (normal), or DONE directly (fast path). Otherwise stay.
//  Accept (cycle 0): latch op; latch |a| and |b| (signed ops) or raw a/b (unsigned).
//    Latch sign flags: qneg = a[XLEN-1]^b[XLEN-1] (signed ops, b!=0);
//    rneg = a[XLEN-1] (signed ops).
//  CALC: one iteration per cycle.
//    rem = {rem[XLEN-2:0], dvd[XLEN-1]}; subtract divisor if rem >= divisor; shift
//    the quotient bit in. Counter 0..XLEN-1; after XLEN iterations go to FIX.
//  FIX: one cycle; negate quotient if qneg, negate remainder if rneg; go to DONE.
//  DONE: done=1, busy=0, result driven from the output register; next state IDLE.
//    A start in DONE is accepted (back-to-back, no bubble).
//  Latency (normal): start in cycle 0 -> busy in cycles 1..XLEN+1 -> done in
//    cycle XLEN+2 (34 for XLEN=32).
//  Fast path: done in cycle 1; busy stays 0.
//    b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//    Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF):
//      DIV -> 0x80000000, REM -> 0.
//  Remainder sign follows the dividend; quotient truncates toward zero.
//  start while busy=1: ignored. Operands are not re-sampled; no error signal.
//  flush: any state -> IDLE next edge; done is not pulsed; result holds its old value.
//    flush has priority over start in the same cycle.
//  result updates only on entry to DONE. Between requests it is stable.
//  rst_n asserted mid-operation: immediate return to the reset values above.
//  All arithmetic is unsigned XLEN-bit on magnitudes. The partial remainder is
//    XLEN+1 bits so the compare does not overflow.
// TESTING
//  DIV a=100 b=7, start cycle 0 -> busy cycles 1..33, done cycle 34,
//    result=14; REM same operands -> 2.
//  REM a=-7 (0xFFFFFFF9) b=2 -> result 0xFFFFFFFF (-1); DIV same -> 0xFFFFFFFD (-3).
//  DIVU a=0xFFFFFFFF b=1 -> 0xFFFFFFFF; REMU a=0xFFFFFFFF b=0x10 -> 0xF.
//  DIV a=5 b=0 -> done cycle 1, result 0xFFFFFFFF; REM a=5 b=0 -> 5; busy never high.
//  DIV a=0x80000000 b=0xFFFFFFFF -> done cycle 1, result 0x80000000; REM -> 0.
//  Abort and overlap cases, from a prior result R:
//    flush at cycle 10 of a DIV -> IDLE at cycle 11, no done, result stays R.
//    start at cycle 5 while busy -> ignored.
//    rst_n low at cycle 20 -> busy=0, result=0 immediately.

Source files
------------

// File: rtl/div_seq_unit.sv
// Sequential radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU.
// Produces one quotient bit per clock and has a single-cycle path for divide-by-zero and signed overflow.
module div_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic            op_rem;
  logic            qneg;
  logic            rneg;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem;

  logic            is_signed;
  logic            b_zero;
  logic            ovf;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] fast_result;
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] rem_diff;
  logic            ge;
  logic            last;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    is_signed = ~op[0];
    b_zero    = (b == '0);
    ovf       = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    abs_a     = (is_signed && a[XLEN-1]) ? -a : a;
    abs_b     = (is_signed && b[XLEN-1]) ? -b : b;

    fast_result = '0;
    if (b_zero)   fast_result = op[1] ? a : '1;
    else if (ovf) fast_result = op[1] ? '0 : a;

    // The shifted partial remainder needs XLEN+1 bits for the compare; once the divisor is
    // subtracted, the result is below the divisor, so the low XLEN bits of the difference are exact.
    rem_shift = {rem, dvd[XLEN-1]};
    ge        = (rem_shift >= {1'b0, dvs});
    rem_diff  = rem_shift[XLEN-1:0] - dvs;
    last      = (counter == CW'(XLEN-1));

    quo_fix = qneg ? -dvd : dvd;
    rem_fix = rneg ? -rem : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      counter <= '0;
      op_rem  <= 1'b0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
    end else if (flush) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      counter <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            op_rem <= op[1];
            if (b_zero || ovf) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= fast_result;
            end else begin
              state   <= CALC;
              busy    <= 1'b1;
              dvd     <= abs_a;
              dvs     <= abs_b;
              rem     <= '0;
              counter <= '0;
              qneg    <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
              rneg    <= is_signed && a[XLEN-1];
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          // dvd doubles as the quotient: dividend bits shift out the top while quotient bits enter at the bottom.
          dvd     <= {dvd[XLEN-2:0], ge};
          rem     <= ge ? rem_diff : rem_shift[XLEN-1:0];
          counter <= counter + 1'b1;
          if (last) state <= FIX;
        end
        FIX: begin
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= op_rem ? rem_fix : quo_fix;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Scoreboard bench for div_seq_unit: the driver queues expected result and done cycle,
// and a negedge monitor pops and compares on every done pulse.
module tb_div_seq_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int unsigned LAT_N = 34;
  localparam int unsigned LAT_F = 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
    int unsigned id;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          errors;
  int unsigned next_id;

  div_seq_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("result#%0d", e.id), result, e.res);
        chk($sformatf("done_cycle#%0d", e.id), cyc, e.cyc);
      end
    end
  end

  // Called just after a rising edge; start is high for that one cycle (cycle 0).
  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] expv, input int unsigned lat);
    exp_t e;
    start = 1'b1;
    op = o;
    a = av;
    b = bv;
    e.res = expv;
    e.cyc = cyc + lat;
    e.id  = next_id;
    next_id++;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    chk($sformatf("busy_cycle1#%0d", e.id), {31'b0, busy}, (lat == LAT_N) ? 32'd1 : 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0 pending", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] expv, input int unsigned lat);
    issue(o, av, bv, expv, lat);
    drain();
  endtask

  initial begin
    int unsigned t0;
    checks = 0;
    errors = 0;
    next_id = 0;
    cyc = 0;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal path, 34-cycle latency, busy checked at cycles 1, 33 and 34.
    t0 = cyc;
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, LAT_N);
    while (cyc != t0 + 33) begin @(posedge clk); #1; end
    chk("busy_cycle33", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("busy_cycle34", {31'b0, busy}, 32'd0);
    drain();

    run(OP_REM,  32'd100,       32'd7,         32'd2,          LAT_N);
    run(OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF,  LAT_N);
    run(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD,  LAT_N);
    run(OP_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2,  LAT_N);
    run(OP_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE,  LAT_N);
    run(OP_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2,  LAT_N);
    run(OP_REM,  32'd100,       32'hFFFF_FFF9, 32'd2,          LAT_N);
    run(OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF,  LAT_N);
    run(OP_REMU, 32'hFFFF_FFFF, 32'h10,        32'hF,          LAT_N);
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          LAT_N);
    run(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  LAT_N);

    // Fast paths: done in cycle 1, busy never asserted.
    run(OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF,  LAT_F);
    run(OP_REM,  32'd5,         32'd0,         32'd5,          LAT_F);
    run(OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF,  LAT_F);
    run(OP_REMU, 32'd5,         32'd0,         32'd5,          LAT_F);
    run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  LAT_F);
    run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          LAT_F);

    // Back-to-back: second start lands in the DONE cycle of the first.
    t0 = cyc;
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, LAT_N);
    while (cyc != t0 + 34) begin @(posedge clk); #1; end
    issue(OP_REM, 32'd100, 32'd7, 32'd2, LAT_N);
    drain();

    // Start while busy is ignored.
    t0 = cyc;
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, LAT_N);
    while (cyc != t0 + 5) begin @(posedge clk); #1; end
    start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // Flush at cycle 10: back to IDLE at cycle 11, no done, result holds 14.
    t0 = cyc;
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc != t0 + 10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_result", result, 32'd14);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_result_hold", result, 32'd14);

    // Async reset at cycle 20 of an operation.
    t0 = cyc;
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc != t0 + 20) begin @(posedge clk); #1; end
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_done", {31'b0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(OP_DIV, 32'd1000, 32'd3, 32'd333, LAT_N);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expected: got %0d pending expected 0 pending", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
